// File: rtl/onchip_memory_stream_writer_pkg.sv
// Shared constants, state encoding and parameter check for the on-chip memory stream writer.
// Every other file of the writer imports this package.
package onchip_memory_stream_writer_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 3200;
  localparam int DEF_CNT_W  = 13;
  localparam int BE_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A transfer may not start past the end of memory or be longer than the whole memory.
  function automatic logic params_valid(input int base, input int len, input int depth);
    return (base < depth) && (len <= depth);
  endfunction

endpackage

// File: rtl/onchip_memory_stream_writer_if.sv
// Control/status, sink stream and memory s2 write-port signals of the stream writer.
// The writer uses the slave modport; software, the stream source and the memory see the master side.
interface onchip_memory_stream_writer_if
  import onchip_memory_stream_writer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  length;

  logic [DATA_W-1:0] snk_data;
  logic              snk_valid;
  logic              snk_ready;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;

  logic              busy;
  logic              done;
  logic              error;
  logic [CNT_W-1:0]  words_written;

  modport slave (
    input  start, abort, base_addr, length, snk_data, snk_valid,
    output snk_ready, mem_address, mem_byteenable, mem_chipselect, mem_write,
           mem_writedata, mem_clken, busy, done, error, words_written
  );

  modport master (
    output start, abort, base_addr, length, snk_data, snk_valid,
    input  snk_ready, mem_address, mem_byteenable, mem_chipselect, mem_write,
           mem_writedata, mem_clken, busy, done, error, words_written
  );

endinterface

// File: rtl/onchip_memory_stream_writer_wrap_addr_counter.sv
// Loadable word pointer that steps by one and wraps from DEPTH-1 back to 0.
// Load takes priority over increment.
module wrap_addr_counter
  import onchip_memory_stream_writer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i) begin
      if (ptr_q == ADDR_W'(DEPTH - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/onchip_memory_stream_writer.sv
// Avalon-MM write master filling the on-chip RAM s2 port from a valid/ready stream.
// Each accepted beat becomes one zero-wait-state write on the following cycle.
//
// state | meaning
// IDLE  | waiting for start; parameters checked when start arrives
// RUN   | accepting beats, each one registered as next cycle's write
// FLUSH | final beat's write is on the bus
// DONE  | one-cycle completion pulse, then back to IDLE
module onchip_memory_stream_writer
  import onchip_memory_stream_writer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic                          clk,
  input logic                          reset,
  onchip_memory_stream_writer_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              error_q, error_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [ADDR_W-1:0] ptr;
  logic              ptr_load;
  logic              ptr_inc;
  logic              params_ok;
  logic              snk_ready;
  logic              accept;

  assign params_ok = params_valid(int'(bus.base_addr), int'(bus.length), DEPTH);
  assign snk_ready = (state_q == ST_RUN) && !bus.abort;
  assign accept    = bus.snk_valid && snk_ready;

  wrap_addr_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ptr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ptr_load),
    .load_val_i (bus.base_addr),
    .inc_i      (ptr_inc),
    .ptr_o      (ptr)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    words_d     = words_q;
    error_d     = error_q;
    wr_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ptr_load    = 1'b0;
    ptr_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort has no meaning in IDLE, so a simultaneous start always wins
        if (bus.start) begin
          words_d = '0;
          if (params_ok) begin
            error_d     = 1'b0;
            ptr_load    = 1'b1;
            remaining_d = bus.length;
            state_d     = (bus.length == '0) ? ST_DONE : ST_RUN;
          end else begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          wr_d        = 1'b1;
          addr_d      = ptr;
          wdata_d     = bus.snk_data;
          ptr_inc     = 1'b1;
          words_d     = words_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      words_q     <= '0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      words_q     <= words_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bus.snk_ready      = snk_ready;
  assign bus.mem_address    = addr_q;
  assign bus.mem_byteenable = {BE_W{1'b1}};
  assign bus.mem_chipselect = wr_q;
  assign bus.mem_write      = wr_q;
  assign bus.mem_writedata  = wdata_q;
  assign bus.mem_clken      = 1'b1;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.error          = error_q;
  assign bus.words_written  = words_q;

endmodule

// File: tb/tb_onchip_memory_stream_writer.sv
// Table-driven bench for the stream writer, scored against a cycle-level transfer model.
// Expected bus writes, ready, busy, done, error and word count come from the model, never the DUT.
module tb_onchip_memory_stream_writer;
  import onchip_memory_stream_writer_pkg::*;

  localparam int DEPTH = DEF_DEPTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  onchip_memory_stream_writer_if bus ();

  onchip_memory_stream_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [11:0] base;
    logic [12:0] len;
    int          mode;
    int          abort_after;
    bit          start_abort;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_wr_seen = 0;

  logic        d_start, d_abort, d_valid;
  logic [31:0] d_data;
  logic [11:0] d_base;
  logic [12:0] d_len;

  bit          m_run;
  int          m_acc, m_len, m_base;
  int          exp_done, busy_from, busy_to, words_exp;
  bit          err_exp;
  logic [11:0] hold_addr;
  logic [31:0] hold_data;
  wr_t         expq[$];

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic model_reset();
    m_run     = 1'b0;
    m_acc     = 0;
    m_len     = 0;
    m_base    = 0;
    exp_done  = -1;
    busy_from = 1;
    busy_to   = 0;
    words_exp = 0;
    err_exp   = 1'b0;
    hold_addr = '0;
    hold_data = '0;
    expq.delete();
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance the model.
  task automatic tick();
    bit  exp_wr, exp_rdy, bad;
    wr_t e, n;
    @(negedge clk);
    cyc++;
    bus.start     = d_start;
    bus.abort     = d_abort;
    bus.base_addr = d_base;
    bus.length    = d_len;
    bus.snk_valid = d_valid;
    bus.snk_data  = d_data;
    #1;
    exp_rdy = m_run && !d_abort;
    exp_wr  = (expq.size() > 0) && (expq[0].cyc == cyc);
    if (exp_wr) begin
      e = expq.pop_front();
      hold_addr = e.addr[11:0];
      hold_data = e.data;
      words_exp++;
    end
    if (bus.mem_write === 1'b1) n_wr_seen++;
    chk("mem_write", 32'(bus.mem_write), 32'(exp_wr));
    chk("mem_chipselect", 32'(bus.mem_chipselect), 32'(exp_wr));
    chk("mem_address", 32'(bus.mem_address), 32'(hold_addr));
    chk("mem_writedata", bus.mem_writedata, hold_data);
    chk("mem_byteenable", 32'(bus.mem_byteenable), 32'hF);
    chk("mem_clken", 32'(bus.mem_clken), 32'h1);
    chk("snk_ready", 32'(bus.snk_ready), 32'(exp_rdy));
    chk("busy", 32'(bus.busy), 32'(cyc >= busy_from && cyc <= busy_to));
    chk("done", 32'(bus.done), 32'(cyc == exp_done));
    chk("error", 32'(bus.error), 32'(err_exp));
    chk("words_written", 32'(bus.words_written), 32'(words_exp));

    if (reset) begin
      model_reset();
    end else if (m_run) begin
      if (d_abort) begin
        m_run   = 1'b0;
        busy_to = cyc;
      end else if (d_valid) begin
        n.cyc  = cyc + 1;
        n.addr = (m_base + m_acc) % DEPTH;
        n.data = d_data;
        expq.push_back(n);
        m_acc++;
        if (m_acc == m_len) begin
          m_run    = 1'b0;
          busy_to  = cyc + 1;
          exp_done = cyc + 2;
        end
      end
    end else if (d_start) begin
      bad       = !((int'(d_base) < DEPTH) && (int'(d_len) <= DEPTH));
      err_exp   = bad;
      words_exp = 0;
      busy_from = cyc + 1;
      if (bad || d_len == '0) begin
        busy_to  = cyc;
        exp_done = cyc + 1;
      end else begin
        m_run   = 1'b1;
        m_base  = int'(d_base);
        m_len   = int'(d_len);
        m_acc   = 0;
        busy_to = 2147483647;
      end
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int seen0, budget, i;
    seen0   = n_wr_seen;
    d_base  = v.base;
    d_len   = v.len;
    d_start = 1'b1;
    d_abort = v.start_abort;
    d_valid = 1'b0;
    tick();
    d_start = 1'b0;
    d_abort = 1'b0;
    budget  = int'(v.len) * 3 + 20;
    i = 0;
    while (m_run && i < budget) begin
      case (v.mode)
        0:       d_valid = 1'b1;
        1:       d_valid = (i % 2 == 0);
        default: d_valid = 1'($urandom_range(0, 1));
      endcase
      d_data  = (v.mode == 0) ? 32'h11 * 32'(m_acc + 1) : $urandom;
      d_abort = (v.abort_after >= 0) && (m_acc == v.abort_after);
      tick();
      i++;
    end
    d_abort = 1'b0;
    if (m_run) begin
      n_cmp++;
      n_bad++;
      $display("FAIL transfer_timeout vec %0d: accepted %0d of %0d beats within %0d cycles", idx, m_acc, m_len, budget);
      finish_run();
    end
    repeat (4) begin
      d_valid = 1'($urandom_range(0, 1));
      d_data  = $urandom;
      tick();
    end
    d_valid = 1'b0;
    chk($sformatf("vec%0d_writes", idx), 32'(n_wr_seen - seen0), 32'(v.exp_writes));
    chk($sformatf("vec%0d_error", idx), 32'(bus.error), 32'(v.exp_err));
    chk($sformatf("vec%0d_words", idx), 32'(bus.words_written), 32'(v.exp_writes));
    chk($sformatf("vec%0d_pending", idx), 32'(expq.size()), 32'h0);
  endtask

  initial begin
    vecs[0] = '{base: 12'd0,    len: 13'd4,    mode: 0, abort_after: -1, start_abort: 1'b0, exp_err: 1'b0, exp_writes: 4};
    vecs[1] = '{base: 12'd3198, len: 13'd4,    mode: 0, abort_after: -1, start_abort: 1'b0, exp_err: 1'b0, exp_writes: 4};
    vecs[2] = '{base: 12'd100,  len: 13'd0,    mode: 0, abort_after: -1, start_abort: 1'b0, exp_err: 1'b0, exp_writes: 0};
    vecs[3] = '{base: 12'd3200, len: 13'd4,    mode: 0, abort_after: -1, start_abort: 1'b0, exp_err: 1'b1, exp_writes: 0};
    vecs[4] = '{base: 12'd5,    len: 13'd3201, mode: 0, abort_after: -1, start_abort: 1'b0, exp_err: 1'b1, exp_writes: 0};
    vecs[5] = '{base: 12'd10,   len: 13'd3,    mode: 0, abort_after: -1, start_abort: 1'b0, exp_err: 1'b0, exp_writes: 3};
    vecs[6] = '{base: 12'd20,   len: 13'd8,    mode: 1, abort_after: -1, start_abort: 1'b0, exp_err: 1'b0, exp_writes: 8};
    vecs[7] = '{base: 12'd40,   len: 13'd8,    mode: 0, abort_after: 3,  start_abort: 1'b0, exp_err: 1'b0, exp_writes: 3};
    vecs[8] = '{base: 12'd3199, len: 13'd1,    mode: 0, abort_after: -1, start_abort: 1'b1, exp_err: 1'b0, exp_writes: 1};
    vecs[9] = '{base: 12'd7,    len: 13'd3200, mode: 0, abort_after: -1, start_abort: 1'b0, exp_err: 1'b0, exp_writes: 3200};
    vecs[10].base        = 12'($urandom_range(0, DEPTH - 1));
    vecs[10].len         = 13'($urandom_range(1, 40));
    vecs[10].mode        = 2;
    vecs[10].abort_after = -1;
    vecs[10].start_abort = 1'b0;
    vecs[10].exp_err     = 1'b0;
    vecs[10].exp_writes  = int'(vecs[10].len);
    vecs[11].base        = 12'($urandom_range(DEPTH - 20, DEPTH - 1));
    vecs[11].len         = 13'($urandom_range(10, 40));
    vecs[11].mode        = 2;
    vecs[11].abort_after = int'($urandom_range(0, 9));
    vecs[11].start_abort = 1'b0;
    vecs[11].exp_err     = 1'b0;
    vecs[11].exp_writes  = vecs[11].abort_after;

    reset   = 1'b1;
    d_start = 1'b0;
    d_abort = 1'b0;
    d_valid = 1'b0;
    d_data  = '0;
    d_base  = '0;
    d_len   = '0;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    tick();

    for (int k = 0; k < 12; k++) begin
      run_vec(k, vecs[k]);
    end

    // Reset while a write is on the bus: the write must vanish without waiting for a clock.
    d_base  = 12'd50;
    d_len   = 13'd8;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    d_valid = 1'b1;
    repeat (3) begin
      d_data = $urandom;
      tick();
    end
    chk("pre_reset_write", 32'(bus.mem_write), 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_mem_write", 32'(bus.mem_write), 32'h0);
    chk("rst_mem_chipselect", 32'(bus.mem_chipselect), 32'h0);
    chk("rst_mem_address", 32'(bus.mem_address), 32'h0);
    chk("rst_mem_writedata", bus.mem_writedata, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_words", 32'(bus.words_written), 32'h0);
    chk("rst_snk_ready", 32'(bus.snk_ready), 32'h0);
    chk("rst_byteenable", 32'(bus.mem_byteenable), 32'hF);
    model_reset();
    d_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    run_vec(12, vecs[0]);

    finish_run();
  end

endmodule
